// File: rtl/mem_wb_skid_if.sv
// MEM -> WB handshake bundle: incoming instruction fields, outgoing head entry and
// the derived write-back / forwarding signals.
interface mem_wb_skid_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    // MEM side
    logic              in_valid;
    logic              in_ready;
    logic              WriteRegIn;
    logic              MemToRegIn;
    logic [DATA_W-1:0] dataMemoryDataIn;
    logic [DATA_W-1:0] ALUResultIn;
    logic [REG_W-1:0]  registerIn;

    // WB side
    logic              out_valid;
    logic              out_ready;
    logic              WriteRegOut;
    logic              MemToRegOut;
    logic [DATA_W-1:0] dataMemoryDataOut;
    logic [DATA_W-1:0] ALUResultOut;
    logic [REG_W-1:0]  registerOut;
    logic [DATA_W-1:0] writeData;
    logic              regWriteEn;
    logic              fwdValid;

    // Environment view: drives instructions in and the WB ready.
    modport master (
        output in_valid, WriteRegIn, MemToRegIn, dataMemoryDataIn, ALUResultIn, registerIn,
        output out_ready,
        input  in_ready,
        input  out_valid, WriteRegOut, MemToRegOut, dataMemoryDataOut, ALUResultOut,
        input  registerOut, writeData, regWriteEn, fwdValid
    );

    // Skid buffer view.
    modport slave (
        input  in_valid, WriteRegIn, MemToRegIn, dataMemoryDataIn, ALUResultIn, registerIn,
        input  out_ready,
        output in_ready,
        output out_valid, WriteRegOut, MemToRegOut, dataMemoryDataOut, ALUResultOut,
        output registerOut, writeData, regWriteEn, fwdValid
    );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register built as a 2-entry skid buffer. in_ready is registered so
// the MEM stage never sees a combinational path from the WB stage's out_ready.
module mem_wb_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mem_wb_skid_if.slave      bus
);

    typedef struct packed {
        logic              write_reg;
        logic              mem_to_reg;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_res;
        logic [REG_W-1:0]  rd;
    } entry_t;

    // Occupancy: head holds the oldest entry, skid only used when full.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   consume;
    logic   out_valid;
    logic   fwd;

    // Pack incoming fields and decode the two handshakes.
    always_comb begin
        in_entry.write_reg  = bus.WriteRegIn;
        in_entry.mem_to_reg = bus.MemToRegIn;
        in_entry.mem_data   = bus.dataMemoryDataIn;
        in_entry.alu_res    = bus.ALUResultIn;
        in_entry.rd         = bus.registerIn;
        out_valid           = (state_q != StEmpty);
        accept              = bus.in_valid & in_ready_q;
        consume             = out_valid & bus.out_ready;
    end

    // Next occupancy and storage contents; flush discards everything, including
    // an instruction arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && consume) begin
                    head_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = StFull;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only a consume can happen.
                if (consume) begin
                    head_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        if (flush) begin
            state_d = StEmpty;
            head_d  = '0;
            skid_d  = '0;
        end
        in_ready_d = (state_d != StFull);
    end

    // State register with synchronous reset overriding everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    // Outputs come straight from the head; enables are gated so stale head
    // contents never leak out while empty, and r0 is never a write target.
    always_comb begin
        fwd                   = out_valid & head_q.write_reg & (head_q.rd != '0);
        bus.in_ready          = in_ready_q;
        bus.out_valid         = out_valid;
        bus.WriteRegOut       = head_q.write_reg;
        bus.MemToRegOut       = head_q.mem_to_reg;
        bus.dataMemoryDataOut = head_q.mem_data;
        bus.ALUResultOut      = head_q.alu_res;
        bus.registerOut       = head_q.rd;
        bus.writeData         = head_q.mem_to_reg ? head_q.mem_data : head_q.alu_res;
        bus.fwdValid          = fwd;
        bus.regWriteEn        = fwd & bus.out_ready;
    end

endmodule
